// File: rtl/bank_timing_tracker_pkg.sv
// Shared types for the per-bank DRAM timing tracker.
// Command encodings and last-command codes used by scheduler and arbiter.
package bank_timing_tracker_pkg;

  typedef enum logic [2:0] {
    NOP  = 3'd0,
    ACT  = 3'd1,
    RD   = 3'd2,
    WR   = 3'd3,
    PRE  = 3'd4,
    PREA = 3'd5,
    REF  = 3'd6
  } cmd_t;

  typedef enum logic [2:0] {
    CODE_IDLE                 = 3'd0,
    CODE_ACTIVE_TO_READ_WRITE = 3'd1,
    CODE_READ_TO_PRECHARGE    = 3'd2,
    CODE_WRITE_TO_PRECHARGE   = 3'd3,
    CODE_PRECHARGE_TO_ACTIVE  = 3'd4,
    CODE_PRECHARGE_TO_REFRESH = 3'd5
  } recode_state_t;

  // Clock cycles the data bus is busy for one burst.
  localparam int BL8_CYCLES = 4;
  localparam int BL4_CYCLES = 2;

endpackage

// File: rtl/bank_timing_tracker_if.sv
// Command/qualifier bundle between command decode,
// the timing tracker and the arbiter.
interface bank_timing_tracker_if #(
  parameter int NUM_BANKS = 8
) ();
  import bank_timing_tracker_pkg::*;

  localparam int BA_W = $clog2(NUM_BANKS);

  logic                 cmd_valid;
  cmd_t                 cmd_type;
  logic [BA_W-1:0]      cmd_bank;
  logic [1:0]           burst_len;
  logic                 auto_pre;
  logic                 refresh_flag;
  logic [NUM_BANKS-1:0] act_ok;
  logic [NUM_BANKS-1:0] rw_ok;
  logic [NUM_BANKS-1:0] pre_ok;
  logic                 ref_ok;
  logic [NUM_BANKS-1:0] bank_open;
  recode_state_t [NUM_BANKS-1:0] recode;
  logic                 cmd_err;

  modport master (
    output cmd_valid, cmd_type, cmd_bank,
    output burst_len, auto_pre, refresh_flag,
    input  act_ok, rw_ok, pre_ok, ref_ok,
    input  bank_open, recode, cmd_err
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_bank,
    input  burst_len, auto_pre, refresh_flag,
    output act_ok, rw_ok, pre_ok, ref_ok,
    output bank_open, recode, cmd_err
  );

endinterface

// File: rtl/bank_timing_tracker_bank_timer.sv
// Per-bank timing counters, open/auto-precharge flags
// and the bank's act/rw/pre qualifiers.
module bank_timer
  import bank_timing_tracker_pkg::*;
#(
  parameter int CNT_W = 6,
  parameter int T_RCD = 6,
  parameter int T_RP  = 6,
  parameter int T_RAS = 15,
  parameter int T_RC  = 21,
  parameter int T_RTP = 4,
  parameter int T_WL  = 5,
  parameter int T_WR  = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          act,
  input  logic          rd,
  input  logic          wr,
  input  logic          pre,
  input  logic          bl4,
  input  logic          auto_pre,
  input  logic          refresh_flag,
  input  logic          glb_ok,
  output logic          act_ok,
  output logic          rw_ok,
  output logic          pre_ok,
  output logic          open,
  output logic          ap_pending,
  output logic          tp_zero,
  output recode_state_t recode
);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t LD_RCD = cnt_t'(T_RCD - 1);
  localparam cnt_t LD_RP  = cnt_t'(T_RP - 1);
  localparam cnt_t LD_RAS = cnt_t'(T_RAS - 1);
  localparam cnt_t LD_RC  = cnt_t'(T_RC - 1);
  localparam cnt_t LD_RTP = cnt_t'(T_RTP - 1);
  localparam cnt_t LD_WR8 =
    cnt_t'(T_WL + BL8_CYCLES + T_WR - 1);
  localparam cnt_t LD_WR4 =
    cnt_t'(T_WL + BL4_CYCLES + T_WR - 1);

  function automatic cnt_t dec(cnt_t c);
    return (c == '0) ? c : c - cnt_t'(1);
  endfunction

  cnt_t tp_cnt;
  cnt_t rcd_cnt;
  cnt_t ras_cnt;
  cnt_t rc_cnt;
  logic ras_zero;
  logic ap_fire;
  logic close;

  assign tp_zero  = (tp_cnt == '0);
  assign ras_zero = (ras_cnt == '0);
  assign ap_fire  = ap_pending & tp_zero & ras_zero;
  assign close    = pre | ap_fire;

  assign act_ok = ~open & tp_zero & (rc_cnt == '0) & glb_ok;
  assign rw_ok  = open & ~ap_pending & (rcd_cnt == '0);
  assign pre_ok = open & ~ap_pending & tp_zero & ras_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tp_cnt     <= '0;
      rcd_cnt    <= '0;
      ras_cnt    <= '0;
      rc_cnt     <= '0;
      open       <= 1'b0;
      ap_pending <= 1'b0;
      recode     <= CODE_IDLE;
    end else begin
      tp_cnt  <= dec(tp_cnt);
      rcd_cnt <= dec(rcd_cnt);
      ras_cnt <= dec(ras_cnt);
      rc_cnt  <= dec(rc_cnt);
      if (act) begin
        open    <= 1'b1;
        rcd_cnt <= LD_RCD;
        ras_cnt <= LD_RAS;
        rc_cnt  <= LD_RC;
        recode  <= CODE_ACTIVE_TO_READ_WRITE;
      end
      if (rd | wr) begin
        tp_cnt <= rd ? LD_RTP : (bl4 ? LD_WR4 : LD_WR8);
        recode <= rd ? CODE_READ_TO_PRECHARGE
                     : CODE_WRITE_TO_PRECHARGE;
        if (auto_pre) ap_pending <= 1'b1;
      end
      // Auto-precharge never carries a refresh intent.
      if (close) begin
        open   <= 1'b0;
        tp_cnt <= LD_RP;
        recode <= (pre & refresh_flag)
                  ? CODE_PRECHARGE_TO_REFRESH
                  : CODE_PRECHARGE_TO_ACTIVE;
      end
      if (ap_fire) ap_pending <= 1'b0;
    end
  end

endmodule

// File: rtl/bank_timing_tracker.sv
// Per-bank DRAM timing tracker: command decode, legality
// check, global tRRD/tRFC counters and bank timer array.
module bank_timing_tracker
  import bank_timing_tracker_pkg::*;
#(
  parameter int NUM_BANKS = 8,
  parameter int CNT_W     = 6,
  parameter int T_RCD     = 6,
  parameter int T_RP      = 6,
  parameter int T_RAS     = 15,
  parameter int T_RC      = 21,
  parameter int T_RRD     = 4,
  parameter int T_RTP     = 4,
  parameter int T_WL      = 5,
  parameter int T_WR      = 6,
  parameter int T_RFC     = 44
) (
  input logic clk,
  input logic rst_n,
  bank_timing_tracker_if.slave bus
);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [NUM_BANKS-1:0] vec_t;

  function automatic cnt_t dec(cnt_t c);
    return (c == '0) ? c : c - cnt_t'(1);
  endfunction

  cnt_t rrd_cnt;
  cnt_t rfc_cnt;
  logic err_q;
  logic glb_ok;
  logic legal;
  logic prea_ok;
  logic ref_ok;
  logic bl4;
  logic is_act, is_rd, is_wr, is_pre, is_prea, is_ref;
  vec_t sel;
  vec_t act_v, rd_v, wr_v, pre_v;
  vec_t act_ok, rw_ok, pre_ok, open, ap_pend, tp_zero;
  recode_state_t [NUM_BANKS-1:0] recode;

  assign is_act  = bus.cmd_valid & (bus.cmd_type == ACT);
  assign is_rd   = bus.cmd_valid & (bus.cmd_type == RD);
  assign is_wr   = bus.cmd_valid & (bus.cmd_type == WR);
  assign is_pre  = bus.cmd_valid & (bus.cmd_type == PRE);
  assign is_prea = bus.cmd_valid & (bus.cmd_type == PREA);
  assign is_ref  = bus.cmd_valid & (bus.cmd_type == REF);

  assign sel = vec_t'(1) << bus.cmd_bank;
  assign bl4 = (bus.burst_len == 2'b10)
             | (bus.burst_len == 2'b11);

  assign glb_ok  = (rrd_cnt == '0) & (rfc_cnt == '0);
  assign prea_ok = (&(pre_ok | ~open)) & ~(|ap_pend);
  assign ref_ok  = ~(|open) & (&tp_zero)
                 & (rfc_cnt == '0);

  always_comb begin
    legal = 1'b1;
    unique case (1'b1)
      is_act:        legal = |(act_ok & sel);
      is_rd | is_wr: legal = |(rw_ok & sel);
      is_pre:        legal = |(pre_ok & sel);
      is_prea:       legal = prea_ok;
      is_ref:        legal = ref_ok;
      default:       legal = 1'b1;
    endcase
  end

  assign act_v = {NUM_BANKS{is_act & legal}} & sel;
  assign rd_v  = {NUM_BANKS{is_rd & legal}} & sel;
  assign wr_v  = {NUM_BANKS{is_wr & legal}} & sel;
  assign pre_v = ({NUM_BANKS{is_pre & legal}} & sel)
               | ({NUM_BANKS{is_prea & legal}} & open);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrd_cnt <= '0;
      rfc_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      rrd_cnt <= (is_act & legal) ? cnt_t'(T_RRD - 1)
                                  : dec(rrd_cnt);
      rfc_cnt <= (is_ref & legal) ? cnt_t'(T_RFC - 1)
                                  : dec(rfc_cnt);
      err_q   <= bus.cmd_valid & ~legal;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    bank_timer #(
      .CNT_W (CNT_W),
      .T_RCD (T_RCD),
      .T_RP  (T_RP),
      .T_RAS (T_RAS),
      .T_RC  (T_RC),
      .T_RTP (T_RTP),
      .T_WL  (T_WL),
      .T_WR  (T_WR)
    ) u_timer (
      .clk          (clk),
      .rst_n        (rst_n),
      .act          (act_v[b]),
      .rd           (rd_v[b]),
      .wr           (wr_v[b]),
      .pre          (pre_v[b]),
      .bl4          (bl4),
      .auto_pre     (bus.auto_pre),
      .refresh_flag (bus.refresh_flag),
      .glb_ok       (glb_ok),
      .act_ok       (act_ok[b]),
      .rw_ok        (rw_ok[b]),
      .pre_ok       (pre_ok[b]),
      .open         (open[b]),
      .ap_pending   (ap_pend[b]),
      .tp_zero      (tp_zero[b]),
      .recode       (recode[b])
    );
  end

  assign bus.act_ok    = act_ok;
  assign bus.rw_ok     = rw_ok;
  assign bus.pre_ok    = pre_ok;
  assign bus.ref_ok    = ref_ok;
  assign bus.bank_open = open;
  assign bus.recode    = recode;
  assign bus.cmd_err   = err_q;

endmodule

// File: tb/tb_bank_timing_tracker.sv
// Scoreboard bench for bank_timing_tracker: a timestamp-based
// reference model predicts every cycle's qualifiers.
module tb_bank_timing_tracker;
  import bank_timing_tracker_pkg::*;

  localparam int NB    = 8;
  localparam int T_RCD = 6;
  localparam int T_RP  = 6;
  localparam int T_RAS = 15;
  localparam int T_RC  = 21;
  localparam int T_RRD = 4;
  localparam int T_RTP = 4;
  localparam int T_WL  = 5;
  localparam int T_WR  = 6;
  localparam int T_RFC = 44;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bank_timing_tracker_if #(.NUM_BANKS(NB)) bus ();

  bank_timing_tracker #(.NUM_BANKS(NB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [NB-1:0]   act;
    logic [NB-1:0]   rw;
    logic [NB-1:0]   pre;
    logic [NB-1:0]   opn;
    logic            rdy;
    logic            err;
    logic [3*NB-1:0] rc;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  // Model: each constraint is the first cycle it is satisfied.
  bit            m_open[NB];
  bit            m_ap[NB];
  recode_state_t m_rc[NB];
  int t_tp[NB], t_rcd[NB], t_ras[NB], t_rc[NB];
  int t_rrd, t_rfc, now;
  bit m_err;

  function automatic bit m_act_ok(int b);
    return !m_open[b] && now >= t_tp[b] && now >= t_rc[b]
        && now >= t_rrd && now >= t_rfc;
  endfunction

  function automatic bit m_rw_ok(int b);
    return m_open[b] && !m_ap[b] && now >= t_rcd[b];
  endfunction

  function automatic bit m_pre_ok(int b);
    return m_open[b] && !m_ap[b] && now >= t_tp[b]
        && now >= t_ras[b];
  endfunction

  function automatic bit m_ref_ok();
    for (int i = 0; i < NB; i++)
      if (m_open[i] || now < t_tp[i]) return 1'b0;
    return now >= t_rfc;
  endfunction

  function automatic bit m_prea_ok();
    for (int i = 0; i < NB; i++) begin
      if (m_ap[i]) return 1'b0;
      if (m_open[i] && !m_pre_ok(i)) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic bit m_legal(cmd_t c, int b);
    case (c)
      ACT:     return m_act_ok(b);
      RD, WR:  return m_rw_ok(b);
      PRE:     return m_pre_ok(b);
      PREA:    return m_prea_ok();
      REF:     return m_ref_ok();
      default: return 1'b1;
    endcase
  endfunction

  function automatic exp_t model_exp();
    exp_t e;
    e = '0;
    for (int i = 0; i < NB; i++) begin
      e.act[i] = m_act_ok(i);
      e.rw[i]  = m_rw_ok(i);
      e.pre[i] = m_pre_ok(i);
      e.opn[i] = m_open[i];
      e.rc[3*i +: 3] = m_rc[i];
    end
    e.rdy = m_ref_ok();
    e.err = m_err;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_open[i] = 0; m_ap[i] = 0; m_rc[i] = CODE_IDLE;
      t_tp[i] = 0; t_rcd[i] = 0; t_ras[i] = 0; t_rc[i] = 0;
    end
    t_rrd = 0; t_rfc = 0; now = 0; m_err = 0;
  endtask

  task automatic m_close(int b, bit rf);
    m_open[b] = 0;
    t_tp[b] = now + T_RP;
    m_rc[b] = rf ? CODE_PRECHARGE_TO_REFRESH
                 : CODE_PRECHARGE_TO_ACTIVE;
  endtask

  task automatic drive_idle();
    bus.cmd_valid = 1'b0; bus.cmd_type = NOP;
    bus.cmd_bank = '0; bus.burst_len = 2'b00;
    bus.auto_pre = 1'b0; bus.refresh_flag = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    sb.push_back(model_exp());
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One command cycle; called at a negedge, returns at the next.
  task automatic step(cmd_t c, int b, logic [1:0] bl,
                      bit ap, bit rf);
    bit lg;
    bit fire[NB];
    int beats;
    bus.cmd_valid = (c != NOP) ? 1'b1 : 1'($urandom_range(1));
    bus.cmd_type = c; bus.cmd_bank = 3'(b);
    bus.burst_len = bl; bus.auto_pre = ap;
    bus.refresh_flag = rf;
    lg = m_legal(c, b);
    for (int i = 0; i < NB; i++)
      fire[i] = m_ap[i] && now >= t_tp[i] && now >= t_ras[i];
    for (int i = 0; i < NB; i++)
      if (fire[i]) begin m_close(i, 0); m_ap[i] = 0; end
    if (lg) begin
      case (c)
        ACT: begin
          m_open[b] = 1; t_rcd[b] = now + T_RCD;
          t_ras[b] = now + T_RAS; t_rc[b] = now + T_RC;
          t_rrd = now + T_RRD;
          m_rc[b] = CODE_ACTIVE_TO_READ_WRITE;
        end
        RD: begin
          t_tp[b] = now + T_RTP;
          m_rc[b] = CODE_READ_TO_PRECHARGE;
          if (ap) m_ap[b] = 1;
        end
        WR: begin
          beats = bl[1] ? 4 : 8;
          t_tp[b] = now + T_WL + beats / 2 + T_WR;
          m_rc[b] = CODE_WRITE_TO_PRECHARGE;
          if (ap) m_ap[b] = 1;
        end
        PRE: m_close(b, rf);
        PREA:
          for (int i = 0; i < NB; i++)
            if (m_open[i]) m_close(i, rf);
        REF: t_rfc = now + T_RFC;
        default: ;
      endcase
    end
    m_err = !lg;
    now++;
    sb.push_back(model_exp());
    @(negedge clk);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(NOP, 0, 2'b00, 0, 0);
  endtask

  task automatic chk(string nm, logic [31:0] got,
                     logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s @%0t got %h want %h",
               nm, $time, got, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    logic [3*NB-1:0] rc_got;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        rc_got = bus.recode;
        chk("act_ok", 32'(bus.act_ok), 32'(e.act));
        chk("rw_ok", 32'(bus.rw_ok), 32'(e.rw));
        chk("pre_ok", 32'(bus.pre_ok), 32'(e.pre));
        chk("bank_open", 32'(bus.bank_open), 32'(e.opn));
        chk("ref_ok", 32'(bus.ref_ok), 32'(e.rdy));
        chk("cmd_err", 32'(bus.cmd_err), 32'(e.err));
        chk("recode", 32'(rc_got), 32'(e.rc));
      end
    end
  end

  initial begin : stim
    int r, b;
    cmd_t c;
    do_reset();
    idle(3);
    // ACT b2: tRCD, tRRD, tRAS edges
    do_reset();
    step(ACT, 2, 2'b00, 0, 0);
    idle(20);
    // WR BL8 with auto-precharge, then self-close
    do_reset();
    step(ACT, 1, 2'b00, 0, 0);
    idle(9);
    step(WR, 1, 2'b00, 1, 0);
    idle(25);
    // RD to a closed bank is rejected
    do_reset();
    step(RD, 0, 2'b00, 0, 0);
    idle(2);
    // REF with a row open is rejected
    do_reset();
    step(ACT, 0, 2'b00, 0, 0);
    step(REF, 0, 2'b00, 0, 0);
    idle(2);
    // PREA for refresh, REF, then tRFC blackout
    do_reset();
    step(ACT, 0, 2'b00, 0, 0);
    idle(14);
    step(PREA, 0, 2'b00, 0, 1);
    idle(5);
    step(REF, 0, 2'b00, 0, 0);
    idle(48);
    // Random traffic with a mid-run reset
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      if (k == 700) do_reset();
      r = $urandom_range(99);
      if (r < 20)      c = NOP;
      else if (r < 45) c = ACT;
      else if (r < 60) c = RD;
      else if (r < 75) c = WR;
      else if (r < 87) c = PRE;
      else if (r < 93) c = PREA;
      else             c = REF;
      b = $urandom_range(NB - 1);
      if ($urandom_range(3) != 0)
        for (int j = 0; j < NB; j++)
          if (m_legal(c, (b + j) % NB)) begin
            b = (b + j) % NB;
            break;
          end
      step(c, b, 2'($urandom_range(3)),
           1'($urandom_range(1)), 1'($urandom_range(1)));
    end
    idle(2);
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain left %0d want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bank_timing_tracker.md
# bank_timing_tracker

Parametrised per-bank DRAM timing tracker for the command scheduler, for NUM_BANKS banks. It enforces tRCD, tRTP, tWR, tRP, tRAS, tRC, tRRD and tRFC, and records each bank's last-command code. It performs auto-precharge internally once a bank's write-recovery or read-to-precharge window and its tRAS window have both expired. It sits between the main FSM's command decode and the arbiter, exporting per-bank act_ok/rw_ok/pre_ok qualifiers.

## Interface
- NUM_BANKS, 8: number of tracked banks; BA_W = $clog2(NUM_BANKS).
- CNT_W, 6: width of every timing counter; every T_* must be between 1 and 2^CNT_W inclusive.
- T_RCD 6, T_RP 6, T_RAS 15, T_RC 21, T_RRD 4, T_RTP 4, T_WL 5, T_WR 6, T_RFC 44: timing values in clk cycles.
- clk  in  1  clock
- rst_n  in  1  reset: asynchronous, active-low
- cmd_valid  in  1  command issued this cycle
- cmd_type  in  3  cmd_t: NOP, ACT, RD, WR, PRE, PREA, REF
- cmd_bank  in  BA_W  target bank; ignored for PREA and REF
- burst_len  in  2  00 or 01 selects BL8/on-the-fly; 10 or 11 selects BL4
- auto_pre  in  1  RD/WR carries auto-precharge
- refresh_flag  in  1  PRE/PREA precedes a refresh
- act_ok  out  NUM_BANKS  ACT legal to bank b this cycle
- rw_ok  out  NUM_BANKS  RD/WR legal to bank b
- pre_ok  out  NUM_BANKS  PRE legal to bank b
- ref_ok  out  1  REF legal
- bank_open  out  NUM_BANKS  row open
- recode  out  NUM_BANKS × recode_state_t  last-command code per bank
- cmd_err  out  1  one-cycle pulse: illegal command rejected

## Operation
- Per bank: tp_cnt (tRTP/tWR/tRP), rcd_cnt, ras_cnt, rc_cnt, open, ap_pending, recode.
- Global counters: rrd_cnt and rfc_cnt.
- Each counter saturates at 0 and decrements by 1 per cycle unless it is loaded.
- A load of value T-1 in the command cycle c makes the gated condition true from cycle c+T.
- ACT(b):
  - open=1.
  - rcd_cnt=T_RCD-1, ras_cnt=T_RAS-1, rc_cnt=T_RC-1, rrd_cnt=T_RRD-1.
  - recode=CODE_ACTIVE_TO_READ_WRITE.
- RD(b): tp_cnt=T_RTP-1; recode=CODE_READ_TO_PRECHARGE.
- WR(b):
  - BL8: tp_cnt=T_WL+4+T_WR-1.
  - BL4: tp_cnt=T_WL+2+T_WR-1.
  - recode=CODE_WRITE_TO_PRECHARGE.
- RD/WR with auto_pre=1 additionally sets ap_pending.
- PRE(b):
  - open=0, tp_cnt=T_RP-1.
  - recode=CODE_PRECHARGE_TO_REFRESH if refresh_flag, else CODE_PRECHARGE_TO_ACTIVE.
- PREA: applies PRE to every open bank; closed banks are unchanged.
- REF: rfc_cnt=T_RFC-1.
- Internal auto-precharge: in any cycle where ap_pending & tp_cnt==0 & ras_cnt==0 for bank b:
  - the PRE(b) effects apply with refresh_flag treated as 0;
  - ap_pending clears.
- Qualifiers:
  - act_ok[b] = !open & tp_cnt==0 & rc_cnt==0 & rrd_cnt==0 & rfc_cnt==0.
  - rw_ok[b] = open & !ap_pending & rcd_cnt==0.
  - pre_ok[b] = open & !ap_pending & tp_cnt==0 & ras_cnt==0.
  - ref_ok = all banks closed, every tp_cnt==0, rfc_cnt==0.
  - PREA is legal iff pre_ok holds for every open bank and no bank has ap_pending.
- Illegal command (cmd_valid with its qualifier false):
  - no state changes;
  - cmd_err=1 in the following cycle.
- NOP never errors.
- Internal auto-precharge and an external command to a different bank in the same cycle both take effect.

## Timing
- Reset values:
  - all counters 0; open=0, ap_pending=0.
  - recode=CODE_IDLE, cmd_err=0.
  - act_ok all 1, rw_ok and pre_ok all 0, ref_ok=1.
- Qualifiers are combinational from registered state only; there is no cmd→ok combinational path.
- cmd_err is registered, with a latency of 1 cycle.
- Reset asserted mid-operation clears everything immediately, including ap_pending.

## Structure
- cmd_t and recode_state_t go in the usertype package; recode_state_t gets no new codes.
- Sub-module bank_timer, instantiated NUM_BANKS times, holds the per-bank counters, flags and qualifiers.
- The top level holds rrd_cnt, rfc_cnt, decode, error detection and ref_ok.

## Test plan
- Reset, then idle → act_ok=8'hFF, rw_ok=0, ref_ok=1, recode all CODE_IDLE.
- ACT b2 at cycle 0:
  - rw_ok[2] rises at cycle 6;
  - act_ok[3] is 0 until cycle 4;
  - pre_ok[2] rises at cycle 15.
- ACT b1 @0, WR BL8 auto_pre @10:
  - internal precharge in cycle 25, bank_open[1] falls at cycle 26;
  - act_ok[1] rises at cycle 31.
- RD b0 without an open row → command ignored, cmd_err pulses at the next cycle, recode[0] unchanged.
- ACT b0, then REF while open → cmd_err.
- PREA with refresh_flag=1 at cycle 15:
  - recode[0]=CODE_PRECHARGE_TO_REFRESH;
  - ref_ok rises at cycle 21.
- REF @21 → act_ok all 0 through cycle 64, all 1 at cycle 65.
